// File: rtl/pixel_combinator_if.sv
// Bundle between the pixel combinator and its queues and stream sink.
// No logic inside; the combinator drives the checks and the output stream.
// The stream uses valid/ready: data is held while valid is high and ready is low.
interface pixel_combinator_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int RBG_SIZE    = 24,
  parameter int NUM_ENGINES = 4
);
  logic                            start;
  logic [DATA_WIDTH-1:0]           xpixel_check;
  logic [DATA_WIDTH-1:0]           ypixel_check;
  logic [NUM_ENGINES-1:0]          en_i;
  logic [NUM_ENGINES*RBG_SIZE-1:0] colour_i;
  logic                            out_valid;
  logic                            out_ready;
  logic [RBG_SIZE-1:0]             out_data;
  logic                            out_sop;
  logic                            out_eol;
  logic                            busy;
  logic                            frame_done;
  logic                            match_error;

  // Combinator side
  modport master (
    input  start, en_i, colour_i, out_ready,
    output xpixel_check, ypixel_check, out_valid, out_data, out_sop, out_eol,
           busy, frame_done, match_error
  );

  // Queue / sink / controller side
  modport slave (
    output start, en_i, colour_i, out_ready,
    input  xpixel_check, ypixel_check, out_valid, out_data, out_sop, out_eol,
           busy, frame_done, match_error
  );
endinterface

// File: rtl/pixel_combinator.sv
// Raster-order reader: broadcasts each coordinate to all queues, takes the matching colour, streams it out.
// Latency: start -> first out_valid in 3 cycles; best case one pixel every 3 cycles.
// Backpressure: pixel held stable in SEND until out_ready; waits in SCAN indefinitely for a match.
module pixel_combinator #(
  parameter int DATA_WIDTH  = 32,
  parameter int RBG_SIZE    = 24,
  parameter int NUM_ENGINES = 4,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic              clk,
  input  logic              reset,
  pixel_combinator_if.master bus
);

  localparam int SEL_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [DATA_WIDTH-1:0] SENTINEL = '1;
  localparam logic [DATA_WIDTH-1:0] X_LAST   = DATA_WIDTH'(IMG_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST   = DATA_WIDTH'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, CAPTURE, SEND} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  out_valid_q, out_valid_d;
  logic [RBG_SIZE-1:0]   out_data_q, out_data_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eol_q, out_eol_d;
  logic                  frame_done_q, frame_done_d;
  logic                  match_error_q, match_error_d;

  logic [SEL_W-1:0]      pick_idx;
  logic                  multi_match;
  logic [RBG_SIZE-1:0]   cap_colour;

  // Lowest-index matching queue wins; more than one bit set is flagged
  always_comb begin
    pick_idx = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      if (bus.en_i[k]) pick_idx = SEL_W'(k);
    end
    multi_match = |(bus.en_i & (bus.en_i - NUM_ENGINES'(1)));
  end

  // Colour of the selected queue, valid in the cycle after its pop
  always_comb begin
    cap_colour = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (sel_q == SEL_W'(k)) cap_colour = bus.colour_i[k*RBG_SIZE +: RBG_SIZE];
    end
  end

  // Next-state and output-register logic
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    sel_d         = sel_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sop_d     = out_sop_q;
    out_eol_d     = out_eol_q;
    frame_done_d  = 1'b0;
    match_error_d = match_error_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d           = '0;
          y_d           = '0;
          match_error_d = 1'b0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (|bus.en_i) begin
          sel_d = pick_idx;
          if (multi_match) match_error_d = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        out_data_d  = cap_colour;
        out_valid_d = 1'b1;
        out_sop_d   = (x_q == '0) && (y_q == '0);
        out_eol_d   = (x_q == X_LAST);
        state_d     = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else if (x_q == X_LAST) begin
            x_d     = '0;
            y_d     = y_q + DATA_WIDTH'(1);
            state_d = SCAN;
          end else begin
            x_d     = x_q + DATA_WIDTH'(1);
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      sel_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      match_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sel_q         <= sel_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      out_eol_q     <= out_eol_d;
      frame_done_q  <= frame_done_d;
      match_error_q <= match_error_d;
    end
  end

  // Coordinates only leave the block while scanning, so queues cannot match elsewhere
  assign bus.xpixel_check = (state_q == SCAN) ? x_q : SENTINEL;
  assign bus.ypixel_check = (state_q == SCAN) ? y_q : SENTINEL;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_sop      = out_sop_q;
  assign bus.out_eol      = out_eol_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.frame_done   = frame_done_q;
  assign bus.match_error  = match_error_q;

endmodule

// File: doc/pixel_combinator.md
# pixel_combinator

Raster-order reader for the per-engine pixel queues. It walks the frame from (0,0) to (IMG_WIDTH-1, IMG_HEIGHT-1) and broadcasts each coordinate to every queue's check port. It waits for the queue whose front entry matches and takes that queue's colour. It then emits one pixel per coordinate on a ready/valid stream to the display/frame-buffer writer.

## Interface
Parameters:
- DATA_WIDTH, 32, coordinate width (matches queue xpixel/ypixel)
- RBG_SIZE, 24, colour width
- NUM_ENGINES, 4, number of queues/engines
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- xpixel_check  out  DATA_WIDTH  x coordinate broadcast to all queues
- ypixel_check  out  DATA_WIDTH  y coordinate broadcast to all queues
- en_i  in  NUM_ENGINES  per-queue front-matches-coordinate flags
- colour_i  in  NUM_ENGINES*RBG_SIZE  per-queue registered colour_o; engine k at bits [k*RBG_SIZE +: RBG_SIZE]
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts
- out_data  out  RBG_SIZE  pixel colour
- out_sop  out  1  first pixel of frame, qualified by out_valid
- out_eol  out  1  last pixel of a line, qualified by out_valid
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after last pixel accepted
- match_error  out  1  sticky; more than one en_i seen high in SCAN; cleared by accepted start

## Operation
- States: IDLE, SCAN, CAPTURE, SEND.
- IDLE: checks drive SENTINEL (all ones, DATA_WIDTH bits). Engines never generate this coordinate. On start=1: x=0, y=0, clear match_error, go SCAN.
- SCAN: checks drive (x,y). If |en_i, latch the lowest set index into sel and go CAPTURE. If more than one bit is set, also set match_error. Otherwise stay in SCAN indefinitely; there is no timeout.
- CAPTURE: checks drive SENTINEL, so no further queue matches or pops occur. Register out_data <= colour_i slice sel and set out_valid=1. Set out_sop=(x==0 && y==0) and out_eol=(x==IMG_WIDTH-1). Go SEND.
- SEND: hold out_valid, out_data, out_sop and out_eol stable until out_ready=1.
  - On handshake: clear out_valid.
  - If x==IMG_WIDTH-1 && y==IMG_HEIGHT-1: pulse frame_done and go IDLE.
  - Else if x==IMG_WIDTH-1: x=0, y=y+1 and go SCAN.
  - Else: x=x+1 and go SCAN.
- Counters are DATA_WIDTH wide, compare against parameter-1, and never exceed their bounds.
- start while busy is ignored.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, x=y=0, sel=0
  - checks=SENTINEL
  - out_valid=0, out_data=0, out_sop=0, out_eol=0
  - busy=0, frame_done=0, match_error=0
- Coordinates are driven from registered state, so a coordinate is presented for exactly the SCAN cycles.
- Each queue pops on the same edge at which the combinator leaves SCAN. Its colour is valid the next cycle, which is the CAPTURE cycle.
- Latency: start sampled at edge t, SCAN from t+1. If en_i is high at t+1, CAPTURE is at t+2 and out_valid is high from t+3.
- Best-case throughput: one pixel per 3 cycles (SCAN, CAPTURE, SEND with out_ready=1).
- frame_done is high for the single cycle after the final handshake edge, with state=IDLE. busy=0 in that same cycle.
- Reset asserted mid-frame: all outputs return immediately to reset values. Any in-flight pixel is dropped and no frame_done is produced.
- out_ready=1 outside SEND has no effect.

## Test plan
- Reset values: hold reset=0 and toggle start and en_i -> all outputs at reset values, checks=0xFFFFFFFF.
- Single-engine 4x2 frame (IMG_WIDTH=4, IMG_HEIGHT=2), queue model returns colour=0x000100*y+x, out_ready tied 1 -> 8 pixels 0x000000..0x000003, 0x000100..0x000103, one every 3 cycles.
  - out_sop only on pixel 0; out_eol on pixels 3 and 7.
  - frame_done pulses once, one cycle after the last handshake.
- Round-robin 4 engines, each holding every 4th pixel -> output order identical to raster order and sel cycles 0,1,2,3. Engine 2 stalled 20 cycles -> checks held at that coordinate for 20+ cycles and no output during the stall.
- Backpressure: out_ready low for 5 cycles in SEND -> out_data/out_valid/out_sop/out_eol stable, checks=SENTINEL, x/y unchanged; pixel accepted on the first ready cycle.
- Double match: en_i=4'b0110 in SCAN -> engine 1 colour output, match_error=1 and it stays 1 until the next accepted start.
- Reset at pixel 5 of 8 in SEND -> outputs return to reset values immediately, no frame_done. A new start restarts at (0,0) with out_sop=1.
